// File: rtl/i2c_rx_sequencer_pkg.sv
// ============================================================================
// Module      : i2c_rx_sequencer_pkg
// Description : Shared address width and FSM state encoding for the I2C
//               receive sequencer.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package i2c_rx_sequencer_pkg;

  localparam int I2C_ADDR_W = 7;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ADDR     = 3'd1;
  localparam logic [2:0] S_ACK_ADDR = 3'd2;
  localparam logic [2:0] S_DATA     = 3'd3;
  localparam logic [2:0] S_ACK_DATA = 3'd4;
  localparam logic [2:0] S_IGNORE   = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE     = S_IDLE,
    ST_ADDR     = S_ADDR,
    ST_ACK_ADDR = S_ACK_ADDR,
    ST_DATA     = S_DATA,
    ST_ACK_DATA = S_ACK_DATA,
    ST_IGNORE   = S_IGNORE
  } state_t;

endpackage

`default_nettype wire

// File: rtl/i2c_rx_sequencer_byte_receiver.sv
// ============================================================================
// Module      : i2c_rx_sequencer_byte_receiver
// Description : Serial-in shift register; next_o is the byte completed by the
//               current shift, data_o holds the last captured byte.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module i2c_rx_sequencer_byte_receiver (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable_i,
  input  logic       capture_i,
  input  logic       in_i,
  output logic [7:0] next_o,
  output logic [7:0] data_o
);

  // Seven stored bits suffice: the eighth arrives on in_i during the final shift.
  logic [6:0] shift_q;
  logic [7:0] data_q;

  assign next_o = {shift_q, in_i};
  assign data_o = data_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q <= '0;
      data_q  <= '0;
    end else if (enable_i) begin
      shift_q <= next_o[6:0];
      if (capture_i) begin
        data_q <= next_o;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/i2c_rx_sequencer.sv
// ============================================================================
// Module      : i2c_rx_sequencer
// Description : Write-only I2C target receiver: START/STOP detection, address
//               match, ACK drive and one-clock data strobes.
//               Optional: I2C_GENERAL_CALL_EN also accepts address byte 8'h00.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module i2c_rx_sequencer
  import i2c_rx_sequencer_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] ADDR        = 7'h2A,
  parameter int                    SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       addressed,
`ifdef I2C_GENERAL_CALL_EN
  output logic       general_call,
`endif
  output logic       busy
);

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_q, sda_q;
  logic w_scl, w_sda, w_scl_rise, w_scl_fall, w_sda_rise, w_sda_fall;
  logic w_start, w_stop, w_byte_done, w_capture, w_addr_ok;
  logic [7:0] w_byte;

  state_t     state_q;
  logic [2:0] bit_cnt_q;
  logic       shift_en_q, sda_oe_q, rx_valid_q, addressed_q, busy_q;

  // Idle bus is high, so synchronizers reset to 1 to avoid phantom edges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_q      <= 1'b1;
      sda_q      <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
      scl_q      <= scl_sync_q[SYNC_STAGES-1];
      sda_q      <= sda_sync_q[SYNC_STAGES-1];
    end
  end

  assign w_scl       = scl_sync_q[SYNC_STAGES-1];
  assign w_sda       = sda_sync_q[SYNC_STAGES-1];
  assign w_scl_rise  = w_scl & ~scl_q;
  assign w_scl_fall  = ~w_scl & scl_q;
  assign w_sda_rise  = w_sda & ~sda_q;
  assign w_sda_fall  = ~w_sda & sda_q;
  assign w_start     = w_sda_fall & w_scl;
  assign w_stop      = w_sda_rise & w_scl;
  assign w_byte_done = shift_en_q && (bit_cnt_q == 3'd0);
  assign w_capture   = (state_q == ST_DATA) && (bit_cnt_q == 3'd0) && !w_start && !w_stop;

  i2c_rx_sequencer_byte_receiver u_byte_receiver (
    .clk       (clk),
    .reset     (reset),
    .enable_i  (shift_en_q),
    .capture_i (w_capture),
    .in_i      (w_sda),
    .next_o    (w_byte),
    .data_o    (rx_data)
  );

`ifdef I2C_GENERAL_CALL_EN
  logic w_gc_hit, gc_pend_q, general_call_q;
  assign w_gc_hit     = (w_byte == 8'h00);
  assign w_addr_ok    = ((w_byte[7:1] == ADDR) && !w_byte[0]) || w_gc_hit;
  assign general_call = general_call_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gc_pend_q      <= 1'b0;
      general_call_q <= 1'b0;
    end else if (w_start || w_stop) begin
      gc_pend_q      <= 1'b0;
      general_call_q <= 1'b0;
    end else if (state_q == ST_ADDR && w_byte_done) begin
      gc_pend_q <= w_gc_hit;
    end else if (state_q == ST_ACK_ADDR && w_scl_fall && sda_oe_q) begin
      general_call_q <= gc_pend_q;
    end
  end
`else
  assign w_addr_ok = (w_byte[7:1] == ADDR) && !w_byte[0];
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      shift_en_q  <= 1'b0;
      sda_oe_q    <= 1'b0;
      rx_valid_q  <= 1'b0;
      addressed_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      shift_en_q <= 1'b0;
      rx_valid_q <= 1'b0;
      if (w_stop) begin
        state_q     <= ST_IDLE;
        busy_q      <= 1'b0;
        addressed_q <= 1'b0;
        sda_oe_q    <= 1'b0;
      end else if (w_start) begin
        state_q     <= ST_ADDR;
        busy_q      <= 1'b1;
        addressed_q <= 1'b0;
        sda_oe_q    <= 1'b0;
        bit_cnt_q   <= 3'd0;
      end else begin
        case (state_q)
          ST_ADDR, ST_DATA: begin
            if (w_scl_rise) begin
              shift_en_q <= 1'b1;
              bit_cnt_q  <= bit_cnt_q + 3'd1;
            end else if (w_byte_done) begin
              if (state_q == ST_DATA) begin
                rx_valid_q <= 1'b1;
                state_q    <= ST_ACK_DATA;
              end else begin
                state_q <= w_addr_ok ? ST_ACK_ADDR : ST_IGNORE;
              end
            end
          end
          // sda_oe_q doubles as the phase flag: first fall drives, second releases.
          ST_ACK_ADDR, ST_ACK_DATA: begin
            if (w_scl_fall) begin
              if (!sda_oe_q) begin
                sda_oe_q <= 1'b1;
              end else begin
                sda_oe_q  <= 1'b0;
                bit_cnt_q <= 3'd0;
                state_q   <= ST_DATA;
                if (state_q == ST_ACK_ADDR) begin
                  addressed_q <= 1'b1;
                end
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign sda_oe    = sda_oe_q;
  assign rx_valid  = rx_valid_q;
  assign addressed = addressed_q;
  assign busy      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_i2c_rx_sequencer.sv
// ============================================================================
// Module      : tb_i2c_rx_sequencer
// Description : Bit-banged I2C master driving i2c_rx_sequencer with directed
//               and randomized write transfers against a transaction model.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_i2c_rx_sequencer;

  localparam int QTR  = 40;
  localparam int HALF = 80;

  logic       clk, reset, m_scl, m_sda, sda_in;
  logic       sda_oe, rx_valid, addressed, busy;
  logic [7:0] rx_data;
`ifdef I2C_GENERAL_CALL_EN
  logic       general_call;
`endif

  int         n_vec = 0;
  int         n_err = 0;
  int         oe_cnt = 0;
  int         rd_idx = 0;
  logic [7:0] rx_log[$];
  logic [7:0] exp_rx[$];
  logic [7:0] xfer_q[$];

  assign sda_in = m_sda & ~sda_oe;

  i2c_rx_sequencer #(.ADDR(7'h2A), .SYNC_STAGES(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .scl_in       (m_scl),
    .sda_in       (sda_in),
    .sda_oe       (sda_oe),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .addressed    (addressed),
`ifdef I2C_GENERAL_CALL_EN
    .general_call (general_call),
`endif
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid) rx_log.push_back(rx_data);
    if (sda_oe) oe_cnt = oe_cnt + 1;
  end

  function automatic logic addr_accept(input logic [7:0] a);
    addr_accept = (a == {7'h2A, 1'b0});
`ifdef I2C_GENERAL_CALL_EN
    if (a == 8'h00) addr_accept = 1'b1;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; m_scl = 1'b1; #HALF;
    m_sda = 1'b0; #QTR;
    m_scl = 1'b0; #QTR;
  endtask

  task automatic i2c_rep_start();
    m_sda = 1'b1; #QTR;
    m_scl = 1'b1; #QTR;
    m_sda = 1'b0; #QTR;
    m_scl = 1'b0; #QTR;
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; #QTR;
    m_scl = 1'b1; #QTR;
    m_sda = 1'b1; #HALF;
  endtask

  task automatic send_bit(input logic b);
    m_sda = b; #QTR;
    m_scl = 1'b1; #HALF;
    m_scl = 1'b0; #QTR;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    m_sda = 1'b1; #QTR;
    m_scl = 1'b1; #QTR;
    ack = ~sda_in; #QTR;
    m_scl = 1'b0; #QTR;
  endtask

  task automatic check_rx(input string tag);
    check({tag, "_rxcnt"}, rx_log.size() - rd_idx, exp_rx.size());
    for (int i = 0; i < exp_rx.size(); i++)
      if (rd_idx + i < rx_log.size()) check({tag, "_rxdat"}, rx_log[rd_idx + i], exp_rx[i]);
    rd_idx = rx_log.size();
    exp_rx.delete();
  endtask

  // One complete START / address / data... / STOP transfer from xfer_q.
  task automatic run_xfer(input string tag);
    logic ack, acc;
    int   oe0;
    oe0 = oe_cnt;
    acc = addr_accept(xfer_q[0]);
    i2c_start();
    check({tag, "_busy"}, busy, 1);
    send_byte(xfer_q[0], ack);
    check({tag, "_aack"}, ack, acc);
    check({tag, "_addressed"}, addressed, acc);
`ifdef I2C_GENERAL_CALL_EN
    check({tag, "_gc"}, general_call, acc && (xfer_q[0] == 8'h00));
`endif
    for (int i = 1; i < xfer_q.size(); i++) begin
      send_byte(xfer_q[i], ack);
      check({tag, "_dack"}, ack, acc);
      if (acc) exp_rx.push_back(xfer_q[i]);
    end
    check({tag, "_busy_pre_stop"}, busy, 1);
    i2c_stop();
    #HALF;
    check({tag, "_busy_stop"}, busy, 0);
    check({tag, "_addr_stop"}, addressed, 0);
    if (!acc) check({tag, "_no_oe"}, oe_cnt - oe0, 0);
    check_rx(tag);
  endtask

  initial begin
    logic ack;
    #2;
    reset = 1'b1; m_scl = 1'b1; m_sda = 1'b1;
    #20;
    check("rst_oe", sda_oe, 0);
    check("rst_data", rx_data, 0);
    check("rst_valid", rx_valid, 0);
    check("rst_addressed", addressed, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    #HALF;

    xfer_q = '{8'h54, 8'hA5};               run_xfer("wr_a5");
    xfer_q = '{8'h30, 8'h12};               run_xfer("adr30");
    xfer_q = '{8'h55, 8'h66};               run_xfer("read");
    xfer_q = '{8'h54, 8'h11, 8'h22, 8'h33}; run_xfer("multi");
    xfer_q = '{8'h00, 8'h5A};               run_xfer("gcall");

    // Repeated START in the middle of a data byte drops the partial bits.
    i2c_start();
    send_byte(8'h54, ack);
    check("rs_aack1", ack, 1);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    i2c_rep_start();
    check("rs_addressed_clr", addressed, 0);
    check("rs_busy", busy, 1);
    send_byte(8'h54, ack);
    check("rs_aack2", ack, 1);
    send_byte(8'h7E, ack);
    check("rs_dack", ack, 1);
    i2c_stop();
    #HALF;
    exp_rx.push_back(8'h7E);
    check_rx("rs");

    // Asynchronous reset while the data ACK is being driven.
    i2c_start();
    send_byte(8'h54, ack);
    check("ar_aack", ack, 1);
    for (int i = 7; i >= 0; i--) send_bit(i[0] ^ i[1]);
    m_sda = 1'b1;
    check("ar_oe_pre", sda_oe, 1);
    #1; reset = 1'b1; #1;
    check("ar_oe_async", sda_oe, 0);
    check("ar_data", rx_data, 0);
    check("ar_valid", rx_valid, 0);
    check("ar_addressed", addressed, 0);
    check("ar_busy", busy, 0);
    m_scl = 1'b1;
    #(HALF - 2);
    reset = 1'b0;
    #HALF;
    exp_rx.push_back(8'h66);
    check_rx("ar_partial");
    xfer_q = '{8'h54, 8'hC3};               run_xfer("ar_next");

    for (int t = 0; t < 8; t++) begin
      int sel, nd;
      xfer_q.delete();
      sel = $urandom_range(0, 3);
      case (sel)
        0:       xfer_q.push_back(8'h54);
        1:       xfer_q.push_back(8'h55);
        2:       xfer_q.push_back(8'h00);
        default: xfer_q.push_back(8'($urandom_range(0, 255)));
      endcase
      nd = $urandom_range(1, 3);
      for (int k = 0; k < nd; k++) xfer_q.push_back(8'($urandom_range(0, 255)));
      run_xfer("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
